alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 32-bit `ALU` datapath between two requesters, the execute-stage issue port (requester 0) and the branch/address-compare port (requester 1). It arbitrates round-robin with a valid/ready handshake, registers the winning operands and control code, drives the `ALU`, registers the result, and returns it to the owning requester. The block is fully pipelined: it accepts one operation per cycle, and each result appears 2 cycles after acceptance.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width, matching the `ALU` `S`/`T`/`Result` ports.
- `CTR_W`, 3: width of the `ALU` `Ctr` control code.

Ports:
- `clk`  in  1: single clock. Everything is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `req0_valid`  in  1: requester 0 has an operation.
- `req0_ready`  out  1: requester 0 is granted this cycle.
- `req0_s`, `req0_t`  in  WIDTH each: requester 0 operands.
- `req0_ctr`  in  CTR_W: requester 0 `ALU` control code.
- `req1_valid`, `req1_ready`, `req1_s`, `req1_t`, `req1_ctr`: same as requester 0, for requester 1.
- `rsp0_valid`  out  1: `rsp_result` belongs to requester 0. One-cycle pulse.
- `rsp1_valid`  out  1: `rsp_result` belongs to requester 1. One-cycle pulse.
- `rsp_result`  out  WIDTH: registered `ALU` result.
- `busy`  out  1: an operation is in the pipeline (stage-1 or stage-2 valid).

## Operation
- **Grant** is combinational from the `reqN_valid` inputs and the `last_grant` register:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than `last_grant` is granted.
  - Neither valid: no grant.
- At most one `reqN_ready` is high in any cycle. Both are forced to 0 while `reset` is high.
- **Handshake** occurs on a rising edge where `reqN_valid && reqN_ready`.
  - On a handshake, stage 1 loads `s`, `t`, `ctr` and the owner id, and sets `s1_valid`.
  - On a handshake, `last_grant` updates to the granted id.
  - With no handshake, `s1_valid` clears and `last_grant` holds.
- **`ALU` operation:** the `ALU` is driven combinationally from the stage-1 registers. The block does not interpret `Ctr`; it passes it through unmodified.
- **Stage 2** captures `Result`, the owner id and `s1_valid` every edge. `rsp_result` updates only when `s1_valid` is set; otherwise it holds its previous value.
- **Response:** `rspN_valid = s2_valid && (s2_owner == N)`.
- **No backpressure:** there is none on the response side. Requesters must consume the response in the cycle it is presented.
- **Requester rules:**
  - A requester holds `valid` and its operands stable until it sees `ready`.
  - Dropping `valid` before it is granted is allowed and carries no penalty.
- **Reset values:** `last_grant`=1, so requester 0 wins the first tie. `s1_valid`=0, `s2_valid`=0, `rsp_result`=0, `rsp0_valid`=0, `rsp1_valid`=0, `busy`=0.
- **Reset mid-operation:** in-flight stage-1 and stage-2 contents are discarded. No `rspN_valid` pulse occurs in the cycle after reset deasserts.
- **Widths:** `WIDTH` is carried end to end. Overflow and carry behaviour is exactly the `ALU`'s; the block adds no extension bits.

## Timing
- **Latency:** for a handshake at edge k, the result is registered at edge k+1 and `rspN_valid` is high for exactly one cycle, between edges k+1 and k+2.
- **Throughput:** 1 operation per cycle. Back-to-back grants produce back-to-back responses with no bubbles.
- **Alternation:** with both requesters continuously valid, grants alternate 0,1,0,1,… starting with 0 after reset. No requester waits more than 1 cycle.
- **Combinational paths:**
  - `reqN_valid` → `reqN_ready` is combinational, one gate level through the arbiter.
  - There is no path from `reqN_*` operands to any output.
- **Other outputs:** `busy` is purely registered.

## Structure
- **Shared package `alu_pkg`:**
  - `WIDTH` and `CTR_W` constants.
  - `ALU` control-code constants: `ALU_AND`=3'b000, `ALU_OR`=3'b001, `ALU_ADD`=3'b010, `ALU_SUB`=3'b110, `ALU_SLT`=3'b111.
  - Requester-id constants `REQ_EX`=0 and `REQ_BR`=1.
- **Sub-module `rr_arbiter2`:** two-input round-robin grant logic holding `last_grant`, with inputs `clk`, `reset`, `valid[1:0]` and output `grant[1:0]`.
- **Top level:** `alu_arbiter` instantiates `rr_arbiter2` and the existing `ALU` (ports `S`, `T`, `Result`, `Ctr`), and holds the stage-1 and stage-2 registers.

## Test plan
- **Reset and idle:** assert `reset` for 2 cycles with both valids high → both readies 0, all `rsp*_valid` 0, `rsp_result`=0, `busy`=0.
- **Single add:** req0 only, `s`=32'hFFFFFFFF, `t`=32'h7FFFFFFF, `ctr`=`ALU_ADD` → `req0_ready` high the same cycle. 2 cycles after the handshake edge, `rsp0_valid` pulses once with `rsp_result`=32'h7FFFFFFE, and `rsp1_valid` stays 0.
- **Contention:** both valid continuously for 6 cycles:
  - req0 issues `ALU_SUB` 10-3; req1 issues `ALU_OR` 32'hF0 | 32'h0F.
  - Required: grants 0,1,0,1,0,1.
  - Required: responses alternate, carrying 7 on `rsp0_valid` and 32'hFF on `rsp1_valid`, one per cycle with no gaps.
- **Lone requester after a tie:** req1 alone for 3 cycles immediately after a req1 grant → req1 granted on every cycle (no forced idle), with 3 consecutive `rsp1_valid` pulses.
- **Reset mid-flight:** handshake at edge k, then `reset` high at edge k+1 → no `rsp*_valid` pulse afterward, `rsp_result`=0, and the next tie is granted to req0.
- **`SLT` passthrough:** `ctr`=`ALU_SLT`, `s`=32'hFFFFFFFF, `t`=1 → `rsp_result` equals the `ALU` reference model output bit-exactly, i.e. the block does not alter `Ctr`.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU and the alu_arbiter slice.
//   WIDTH / CTR_W : datapath and control-code widths
//   ALU_*         : ALU control codes
//   req_id_t      : requester ids (REQ_EX = execute issue, REQ_BR = branch/address compare)
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CTR_W = 3;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic {
        REQ_EX = 1'b0,
        REQ_BR = 1'b1
    } req_id_t;

endpackage

// File: rtl/ALU.sv
// ALU: combinational 32-bit ALU shared by the execute and branch paths.
//   S, T   : operands
//   Ctr    : control code (ALU_AND/OR/ADD/SUB/SLT); unknown codes give 0
//   Result : WIDTH-bit result, wraps on overflow, no carry out
module ALU #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned CTR_W = alu_pkg::CTR_W
) (
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    input  logic [CTR_W-1:0] Ctr,
    output logic [WIDTH-1:0] Result
);
    import alu_pkg::*;

    always_comb begin
        Result = '0;
        case (Ctr)
            ALU_AND: Result = S & T;
            ALU_OR:  Result = S | T;
            ALU_ADD: Result = S + T;
            ALU_SUB: Result = S - T;
            // Signed compare, result is 0 or 1
            ALU_SLT: Result = {{(WIDTH-1){1'b0}}, ($signed(S) < $signed(T))};
            default: Result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   valid[1:0] : request lines (bit N = requester N)
//   grant[1:0] : one-hot (or zero) grant, combinational from valid and last_grant;
//                forced to zero while reset is high
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    import alu_pkg::*;

    req_id_t last_grant;

    always_comb begin
        grant = '0;
        if (!reset) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Tie: favour whoever did not win last time
                2'b11:   grant = (last_grant == REQ_EX) ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    // A grant always coincides with a handshake, since grant implies valid
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_BR;
        end else if (|grant) begin
            last_grant <= grant[1] ? REQ_BR : REQ_EX;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin grant.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   reqN_valid/ready        : request handshake for requester N (0 = execute, 1 = branch)
//   reqN_s, reqN_t, reqN_ctr: operands and ALU control code
//   rspN_valid              : one-cycle pulse, rsp_result belongs to requester N
//   rsp_result              : registered ALU result (holds when no new result)
//   busy                    : registered, an operation is in stage 1 or stage 2
// Pipeline: handshake loads stage 1, ALU runs off stage 1, stage 2 registers the result.
module alu_arbiter #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned CTR_W = alu_pkg::CTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_s,
    input  logic [WIDTH-1:0] req0_t,
    input  logic [CTR_W-1:0] req0_ctr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_s,
    input  logic [WIDTH-1:0] req1_t,
    input  logic [CTR_W-1:0] req1_ctr,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);
    import alu_pkg::*;

    logic [1:0]       grant;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_s;
    logic [WIDTH-1:0] s1_t;
    logic [CTR_W-1:0] s1_ctr;
    req_id_t          s1_owner;
    logic [WIDTH-1:0] alu_result;
    logic             s2_valid;
    req_id_t          s2_owner;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_t     <= '0;
            s1_ctr   <= '0;
            s1_owner <= REQ_EX;
        end else begin
            s1_valid <= |grant;
            if (grant[1]) begin
                s1_s     <= req1_s;
                s1_t     <= req1_t;
                s1_ctr   <= req1_ctr;
                s1_owner <= REQ_BR;
            end else if (grant[0]) begin
                s1_s     <= req0_s;
                s1_t     <= req0_t;
                s1_ctr   <= req0_ctr;
                s1_owner <= REQ_EX;
            end
        end
    end

    ALU #(
        .WIDTH (WIDTH),
        .CTR_W (CTR_W)
    ) u_alu (
        .S      (s1_s),
        .T      (s1_t),
        .Ctr    (s1_ctr),
        .Result (alu_result)
    );

    // busy is registered from the next-state of both stage valids so it
    // equals s1_valid | s2_valid without a combinational output path
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            s2_owner   <= REQ_EX;
            rsp_result <= '0;
            busy       <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            busy     <= (|grant) | s1_valid;
            if (s1_valid) begin
                rsp_result <= alu_result;
            end
        end
    end

    assign rsp0_valid = s2_valid && (s2_owner == REQ_EX);
    assign rsp1_valid = s2_valid && (s2_owner == REQ_BR);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven directed bench for alu_arbiter.
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs compared 1 time unit later (registered outputs reflect the previous
// rising edge, readies reflect the current inputs).
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_s, req0_t, req1_s, req1_t;
    logic [2:0]  req0_ctr, req1_ctr;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_result;
    logic        busy;

    int unsigned checks;
    int unsigned errors;

    alu_arbiter #(
        .WIDTH (32),
        .CTR_W (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_s     (req0_s),
        .req0_t     (req0_t),
        .req0_ctr   (req0_ctr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_s     (req1_s),
        .req1_t     (req1_t),
        .req1_ctr   (req1_ctr),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] s0;
        logic [31:0] t0;
        logic [2:0]  c0;
        logic        v1;
        logic [31:0] s1;
        logic [31:0] t1;
        logic [2:0]  c1;
        logic        er0;
        logic        er1;
        logic        erv0;
        logic        erv1;
        logic [31:0] eres;
        logic        ebusy;
        logic        chk;
    } vec_t;

    function automatic vec_t row(
        input logic rst,
        input logic v0, input logic [31:0] s0, input logic [31:0] t0, input logic [2:0] c0,
        input logic v1, input logic [31:0] s1, input logic [31:0] t1, input logic [2:0] c1,
        input logic er0, input logic er1, input logic erv0, input logic erv1,
        input logic [31:0] eres, input logic ebusy, input logic chk);
        vec_t r;
        r.rst = rst;
        r.v0 = v0; r.s0 = s0; r.t0 = t0; r.c0 = c0;
        r.v1 = v1; r.s1 = s1; r.t1 = t1; r.c1 = c1;
        r.er0 = er0; r.er1 = er1; r.erv0 = erv0; r.erv1 = erv1;
        r.eres = eres; r.ebusy = ebusy; r.chk = chk;
        return r;
    endfunction

    // Independent reference for the ALU codes
    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply(input vec_t v);
        reset      = v.rst;
        req0_valid = v.v0;
        req0_s     = v.s0;
        req0_t     = v.t0;
        req0_ctr   = v.c0;
        req1_valid = v.v1;
        req1_s     = v.s1;
        req1_t     = v.t1;
        req1_ctr   = v.c1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input vec_t v);
        check({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, v.er0});
        check({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, v.er1});
        if (v.chk) begin
            check({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, {31'd0, v.erv0});
            check({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, {31'd0, v.erv1});
            check({tag, "_rsp_result"}, rsp_result, v.eres);
            check({tag, "_busy"}, {31'd0, busy}, {31'd0, v.ebusy});
        end
    endtask

    localparam int unsigned NROWS = 18;
    vec_t tbl [NROWS];

    vec_t        v;
    logic [31:0] op_s [3];
    logic [31:0] op_t [3];
    logic [2:0]  op_c [3];

    initial begin
        checks = 0;
        errors = 0;

        // Contention operands: req0 10-3, req1 F0|0F
        // rst  v0  s0             t0             c0       v1  s1     t1     c1       r0 r1 rv0 rv1 res            busy chk
        tbl[0]  = row(1, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  0, 0, 0, 0, 32'h0, 0, 0);
        tbl[1]  = row(1, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  0, 0, 0, 0, 32'h0, 0, 1);
        tbl[2]  = row(0, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  1, 0, 0, 0, 32'h0, 0, 1);
        tbl[3]  = row(0, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  0, 1, 0, 0, 32'h0, 1, 1);
        tbl[4]  = row(0, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  1, 0, 1, 0, 32'd7, 1, 1);
        tbl[5]  = row(0, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  0, 1, 0, 1, 32'hFF, 1, 1);
        tbl[6]  = row(0, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  1, 0, 1, 0, 32'd7, 1, 1);
        tbl[7]  = row(0, 1, 32'd10, 32'd3, ALU_SUB, 1, 32'hF0, 32'h0F, ALU_OR,  0, 1, 0, 1, 32'hFF, 1, 1);
        // req1 alone right after its own grant: F0 & 3C = 30
        tbl[8]  = row(0, 0, 32'd0, 32'd0, ALU_ADD, 1, 32'hF0, 32'h3C, ALU_AND, 0, 1, 1, 0, 32'd7, 1, 1);
        tbl[9]  = row(0, 0, 32'd0, 32'd0, ALU_ADD, 1, 32'hF0, 32'h3C, ALU_AND, 0, 1, 0, 1, 32'hFF, 1, 1);
        tbl[10] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 1, 32'hF0, 32'h3C, ALU_AND, 0, 1, 0, 1, 32'h30, 1, 1);
        tbl[11] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,   0, 0, 0, 1, 32'h30, 1, 1);
        tbl[12] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,   0, 0, 0, 1, 32'h30, 1, 1);
        tbl[13] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,   0, 0, 0, 0, 32'h30, 0, 1);
        // Single add with wraparound
        tbl[14] = row(0, 1, 32'hFFFFFFFF, 32'h7FFFFFFF, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND, 1, 0, 0, 0, 32'h30, 0, 1);
        tbl[15] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,   0, 0, 0, 0, 32'h30, 1, 1);
        tbl[16] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,   0, 0, 1, 0, 32'h7FFFFFFE, 1, 1);
        tbl[17] = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,   0, 0, 0, 0, 32'h7FFFFFFE, 0, 1);

        for (int i = 0; i < int'(NROWS); i++) begin
            apply(tbl[i]);
            #1;
            check_row($sformatf("row%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Reset mid-flight: handshake, then reset on the very next edge
        v = row(0, 1, 32'd1, 32'd2, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND, 1, 0, 0, 0, 32'h0, 0, 0);
        apply(v); #1; check_row("rmf_issue", v); @(negedge clk);
        v = row(1, 1, 32'd1, 32'd2, ALU_ADD, 1, 32'hF0, 32'h0F, ALU_OR, 0, 0, 0, 0, 32'h0, 0, 0);
        apply(v); #1; check_row("rmf_reset", v); @(negedge clk);
        v = row(0, 1, 32'd1, 32'd2, ALU_ADD, 1, 32'hF0, 32'h0F, ALU_OR, 1, 0, 0, 0, 32'h0, 0, 1);
        apply(v); #1; check_row("rmf_tie", v); @(negedge clk);
        v = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND, 0, 0, 0, 0, 32'h0, 1, 1);
        apply(v); #1; check_row("rmf_gap", v); @(negedge clk);
        v = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND, 0, 0, 1, 0, 32'd3, 1, 1);
        apply(v); #1; check_row("rmf_resume", v); @(negedge clk);

        // Back-to-back ops on req1 checked against the reference model
        op_s[0] = 32'hFFFFFFFF; op_t[0] = 32'd1;         op_c[0] = ALU_SLT;
        op_s[1] = 32'd1;        op_t[1] = 32'hFFFFFFFF;  op_c[1] = ALU_SLT;
        op_s[2] = 32'd0;        op_t[2] = 32'd1;         op_c[2] = ALU_SUB;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                v = row(0, 0, 32'd0, 32'd0, ALU_ADD, 1, op_s[i], op_t[i], op_c[i],
                        0, 1, 0, 0, 32'h0, 0, 0);
            end else begin
                v = row(0, 0, 32'd0, 32'd0, ALU_ADD, 0, 32'h0, 32'h0, ALU_AND,
                        0, 0, 0, 0, 32'h0, 0, 0);
            end
            apply(v);
            #1;
            check($sformatf("slt%0d_ready1", i), {31'd0, req1_ready}, {31'd0, v.er1});
            if (i >= 2) begin
                check($sformatf("slt%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd1);
                check($sformatf("slt%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd0);
                check($sformatf("slt%0d_result", i), rsp_result,
                      ref_alu(op_c[i-2], op_s[i-2], op_t[i-2]));
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
